// File: rtl/mem_controller_pkg.sv
// rtl/mem_controller_pkg.sv - shared types for the data-memory channel controller
package mem_controller_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 8;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] data_memory_address_t;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_READ_WAIT,
        CH_WRITE_WAIT,
        CH_RELEASE
    } mem_controller_state_t;

endpackage

// File: rtl/mem_controller_rr_picker.sv
// rtl/mem_controller_rr_picker.sv - find first set bit of a mask, scanning upward from a pointer with wrap
module rr_picker #(
    parameter int N  = 8,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req_mask_i,
    input  logic [PW-1:0] ptr_i,
    output logic          found_o,
    output logic [PW-1:0] idx_o
);

    always_comb begin
        int j;
        logic [PW-1:0] jj;
        found_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        jj      = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = PW'(j);
            if (!found_o && req_mask_i[jj]) begin
                found_o = 1'b1;
                idx_o   = jj;
            end
        end
    end

endmodule

// File: rtl/mem_controller.sv
// rtl/mem_controller.sv - shares NUM_CHANNELS data-memory channels among NUM_CONSUMERS LSU requesters
module mem_controller
    import mem_controller_pkg::*;
#(
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CONSUMERS-1:0]   consumer_read_valid,
    input  data_memory_address_t       consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0]   consumer_read_ready,
    output data_t                      consumer_read_data [NUM_CONSUMERS],
    input  logic [NUM_CONSUMERS-1:0]   consumer_write_valid,
    input  data_memory_address_t       consumer_write_address [NUM_CONSUMERS],
    input  data_t                      consumer_write_data [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0]   consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]    mem_read_valid,
    output data_memory_address_t       mem_read_address [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]    mem_read_ready,
    input  data_t                      mem_read_data [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0]    mem_write_valid,
    output data_memory_address_t       mem_write_address [NUM_CHANNELS],
    output data_t                      mem_write_data [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]    mem_write_ready
);

    localparam int PW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    mem_controller_state_t     state_q   [NUM_CHANNELS];
    mem_controller_state_t     state_d   [NUM_CHANNELS];
    logic [PW-1:0]             owner_q   [NUM_CHANNELS];
    logic [PW-1:0]             owner_d   [NUM_CHANNELS];
    logic [PW-1:0]             rr_ptr_q  [NUM_CHANNELS];
    logic [PW-1:0]             rr_ptr_d  [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]  serving_q, serving_d;

    logic [NUM_CHANNELS-1:0]   mrv_q, mrv_d, mwv_q, mwv_d;
    data_memory_address_t      mra_q [NUM_CHANNELS];
    data_memory_address_t      mra_d [NUM_CHANNELS];
    data_memory_address_t      mwa_q [NUM_CHANNELS];
    data_memory_address_t      mwa_d [NUM_CHANNELS];
    data_t                     mwd_q [NUM_CHANNELS];
    data_t                     mwd_d [NUM_CHANNELS];

    logic [NUM_CONSUMERS-1:0]  crr_q, crr_d, cwr_q, cwr_d;
    data_t                     crd_q [NUM_CONSUMERS];
    data_t                     crd_d [NUM_CONSUMERS];

    logic [NUM_CONSUMERS-1:0]  pending;
    logic [NUM_CHANNELS-1:0]   grant;
    logic [PW-1:0]             pick_idx [NUM_CHANNELS];

    assign pending = (consumer_read_valid | consumer_write_valid) & ~serving_q;

    // Each channel sees the pending mask minus whatever lower-numbered channels claimed this cycle.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [NUM_CONSUMERS-1:0] mask_in;
        logic [NUM_CONSUMERS-1:0] mask_out;
        logic                     found;

        if (c == 0) begin : g_head
            assign mask_in = pending;
        end else begin : g_tail
            assign mask_in = g_ch[c-1].mask_out;
        end

        rr_picker #(
            .N  (NUM_CONSUMERS),
            .PW (PW)
        ) u_picker (
            .req_mask_i (mask_in),
            .ptr_i      (rr_ptr_q[c]),
            .found_o    (found),
            .idx_o      (pick_idx[c])
        );

        assign grant[c] = found && (state_q[c] == CH_IDLE);
        assign mask_out = grant[c] ? (mask_in & ~(NUM_CONSUMERS'(1) << pick_idx[c])) : mask_in;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        serving_d = serving_q;
        mrv_d     = mrv_q;
        mra_d     = mra_q;
        mwv_d     = mwv_q;
        mwa_d     = mwa_q;
        mwd_d     = mwd_q;
        crr_d     = crr_q;
        cwr_d     = cwr_q;
        crd_d     = crd_q;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (state_q[c])
                CH_IDLE: begin
                    if (grant[c]) begin
                        serving_d[pick_idx[c]] = 1'b1;
                        owner_d[c]             = pick_idx[c];
                        rr_ptr_d[c]            = (int'(pick_idx[c]) == NUM_CONSUMERS - 1) ? '0
                                                                                          : pick_idx[c] + 1'b1;
                        if (consumer_read_valid[pick_idx[c]]) begin
                            mrv_d[c]   = 1'b1;
                            mra_d[c]   = consumer_read_address[pick_idx[c]];
                            state_d[c] = CH_READ_WAIT;
                        end else begin
                            mwv_d[c]   = 1'b1;
                            mwa_d[c]   = consumer_write_address[pick_idx[c]];
                            mwd_d[c]   = consumer_write_data[pick_idx[c]];
                            state_d[c] = CH_WRITE_WAIT;
                        end
                    end
                end
                CH_READ_WAIT: begin
                    if (mem_read_ready[c]) begin
                        mrv_d[c]          = 1'b0;
                        crd_d[owner_q[c]] = mem_read_data[c];
                        crr_d[owner_q[c]] = 1'b1;
                        state_d[c]        = CH_RELEASE;
                    end
                end
                CH_WRITE_WAIT: begin
                    if (mem_write_ready[c]) begin
                        mwv_d[c]          = 1'b0;
                        cwr_d[owner_q[c]] = 1'b1;
                        state_d[c]        = CH_RELEASE;
                    end
                end
                CH_RELEASE: begin
                    if (!consumer_read_valid[owner_q[c]] && !consumer_write_valid[owner_q[c]]) begin
                        crr_d[owner_q[c]]     = 1'b0;
                        cwr_d[owner_q[c]]     = 1'b0;
                        serving_d[owner_q[c]] = 1'b0;
                        state_d[c]            = CH_IDLE;
                    end
                end
                default: state_d[c] = CH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c]  <= CH_IDLE;
                owner_q[c]  <= '0;
                rr_ptr_q[c] <= '0;
                mra_q[c]    <= '0;
                mwa_q[c]    <= '0;
                mwd_q[c]    <= '0;
            end
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                crd_q[i] <= '0;
            end
            serving_q <= '0;
            mrv_q     <= '0;
            mwv_q     <= '0;
            crr_q     <= '0;
            cwr_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            serving_q <= serving_d;
            mrv_q     <= mrv_d;
            mra_q     <= mra_d;
            mwv_q     <= mwv_d;
            mwa_q     <= mwa_d;
            mwd_q     <= mwd_d;
            crr_q     <= crr_d;
            cwr_q     <= cwr_d;
            crd_q     <= crd_d;
        end
    end

    assign mem_read_valid       = mrv_q;
    assign mem_read_address     = mra_q;
    assign mem_write_valid      = mwv_q;
    assign mem_write_address    = mwa_q;
    assign mem_write_data       = mwd_q;
    assign consumer_read_ready  = crr_q;
    assign consumer_write_ready = cwr_q;
    assign consumer_read_data   = crd_q;

endmodule
